fp_mul_prep: RTL and testbench

Pipelined front-end of the real multiplier: accepts two IEEE-754 operands (single or double, selected by parameter) over a valid/ready handshake, classifies both, and produces the product sign, the biased exponent sum, the two mantissas with hidden bit, and the special-case result class. It sits between the operand source and the mantissa multiplier/normaliser stage. It replaces the purely combinational single-operand classifier with a two-pair, back-pressured, two-stage pipeline.

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_classifier.sv | 47 ++++
 rtl/fp_mul_prep.sv | 175 +++++++++++++++++
 tb/tb_fp_mul_prep.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the multiplier front-end:
// result class codes, bias and format widths.
package fp_pkg;

    localparam logic [1:0] CLASS_NORMAL = 2'd0;
    localparam logic [1:0] CLASS_ZERO   = 2'd1;
    localparam logic [1:0] CLASS_INF    = 2'd2;
    localparam logic [1:0] CLASS_NAN    = 2'd3;

    function automatic int fp_width(bit is_double);
        return is_double ? 64 : 32;
    endfunction

    function automatic int fp_exp_w(bit is_double);
        return is_double ? 11 : 8;
    endfunction

    function automatic int fp_mant_w(bit is_double);
        return is_double ? 52 : 23;
    endfunction

    function automatic int fp_bias(int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_classifier.sv
// Combinational classification of one IEEE-754 operand:
// kind flags, effective exponent and mantissa with hidden bit.
module fp_classifier
    import fp_pkg::*;
#(
    parameter int EXPONENT_W = 8,
    parameter int MANTISSA_W = 23
) (
    input  logic [EXPONENT_W+MANTISSA_W:0] op_i,
    output logic                           sign_o,
    output logic                           nan_o,
    output logic                           snan_o,
    output logic                           inf_o,
    output logic                           zero_o,
    output logic                           denorm_o,
    output logic                           norm_o,
    output logic [EXPONENT_W-1:0]          eff_exp_o,
    output logic [MANTISSA_W:0]            mant_o
);

    logic [EXPONENT_W-1:0] exp_f;
    logic [MANTISSA_W-1:0] frac_f;
    logic                  exp_full;
    logic                  exp_empty;
    logic                  frac_nz;

    assign sign_o = op_i[EXPONENT_W+MANTISSA_W];
    assign exp_f  = op_i[EXPONENT_W+MANTISSA_W-1:MANTISSA_W];
    assign frac_f = op_i[MANTISSA_W-1:0];

    // Field summaries and the derived operand kind
    always_comb begin
        exp_full  = &exp_f;
        exp_empty = ~|exp_f;
        frac_nz   = |frac_f;
        nan_o     = exp_full & frac_nz;
        snan_o    = exp_full & frac_nz & ~frac_f[MANTISSA_W-1];
        inf_o     = exp_full & ~frac_nz;
        zero_o    = exp_empty & ~frac_nz;
        denorm_o  = exp_empty & frac_nz;
        norm_o    = ~exp_full & ~exp_empty;
        // Denormals and zero behave as exponent 1 with no hidden bit
        eff_exp_o = exp_empty ? EXPONENT_W'(1) : exp_f;
        mant_o    = {~exp_empty, frac_f};
    end

endmodule

// File: rtl/fp_mul_prep.sv
// Two-stage back-pressured multiplier front-end: classify both
// operands, then form sign, exponent sum, mantissas and class.
module fp_mul_prep
    import fp_pkg::*;
#(
    parameter bit IS_DOUBLE  = 1'b0,
    parameter int WIDTH      = fp_width(IS_DOUBLE),
    parameter int EXPONENT_W = fp_exp_w(IS_DOUBLE),
    parameter int MANTISSA_W = fp_mant_w(IS_DOUBLE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             op1,
    input  logic [WIDTH-1:0]             op2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sign,
    output logic signed [EXPONENT_W+1:0] out_exp,
    output logic [MANTISSA_W:0]          out_mant1,
    output logic [MANTISSA_W:0]          out_mant2,
    output logic [1:0]                   out_class,
    output logic                         out_invalid
);

    localparam int XW   = EXPONENT_W + 2;
    localparam int BIAS = fp_bias(EXPONENT_W);

    typedef struct packed {
        logic                  sign;
        logic [EXPONENT_W-1:0] e1;
        logic [EXPONENT_W-1:0] e2;
        logic [MANTISSA_W:0]   m1;
        logic [MANTISSA_W:0]   m2;
        logic                  nan1;
        logic                  nan2;
        logic                  snan1;
        logic                  snan2;
        logic                  inf1;
        logic                  inf2;
        logic                  zero1;
        logic                  zero2;
        logic                  fin1;
        logic                  fin2;
    } s1_t;

    typedef struct packed {
        logic                sign;
        logic [XW-1:0]       exp;
        logic [MANTISSA_W:0] m1;
        logic [MANTISSA_W:0] m2;
        logic [1:0]          cls;
        logic                inv;
    } s2_t;

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic v1_d, v1_q;
    logic v2_d, v2_q;
    logic en1, en2;

    logic                  sg1, sg2;
    logic                  nan1, nan2, snan1, snan2;
    logic                  inf1, inf2, zero1, zero2;
    logic                  den1, den2, norm1, norm2;
    logic [EXPONENT_W-1:0] ee1, ee2;
    logic [MANTISSA_W:0]   mt1, mt2;

    fp_classifier #(
        .EXPONENT_W(EXPONENT_W),
        .MANTISSA_W(MANTISSA_W)
    ) u_cls1 (
        .op_i     (op1),
        .sign_o   (sg1),
        .nan_o    (nan1),
        .snan_o   (snan1),
        .inf_o    (inf1),
        .zero_o   (zero1),
        .denorm_o (den1),
        .norm_o   (norm1),
        .eff_exp_o(ee1),
        .mant_o   (mt1)
    );

    fp_classifier #(
        .EXPONENT_W(EXPONENT_W),
        .MANTISSA_W(MANTISSA_W)
    ) u_cls2 (
        .op_i     (op2),
        .sign_o   (sg2),
        .nan_o    (nan2),
        .snan_o   (snan2),
        .inf_o    (inf2),
        .zero_o   (zero2),
        .denorm_o (den2),
        .norm_o   (norm2),
        .eff_exp_o(ee2),
        .mant_o   (mt2)
    );

    // Each stage loads when empty or when the stage after it drains
    always_comb begin
        en2      = !v2_q | out_ready;
        en1      = !v1_q | en2;
        in_ready = en1;
        v1_d     = en1 ? in_valid : v1_q;
        v2_d     = en2 ? v1_q : v2_q;
    end

    // Stage-1 payload: classified operand pair
    always_comb begin
        s1_d       = '0;
        s1_d.sign  = sg1 ^ sg2;
        s1_d.e1    = ee1;
        s1_d.e2    = ee2;
        s1_d.m1    = mt1;
        s1_d.m2    = mt2;
        s1_d.nan1  = nan1;
        s1_d.nan2  = nan2;
        s1_d.snan1 = snan1;
        s1_d.snan2 = snan2;
        s1_d.inf1  = inf1;
        s1_d.inf2  = inf2;
        s1_d.zero1 = zero1;
        s1_d.zero2 = zero2;
        s1_d.fin1  = norm1 | den1;
        s1_d.fin2  = norm2 | den2;
    end

    // Stage-2 payload: exponent sum, result class and invalid flag
    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.exp  = XW'(s1_q.e1) + XW'(s1_q.e2) - XW'(BIAS);
        s2_d.m1   = s1_q.m1;
        s2_d.m2   = s1_q.m2;
        s2_d.inv  = (s1_q.inf1 & s1_q.zero2) | (s1_q.zero1 & s1_q.inf2)
                  | s1_q.snan1 | s1_q.snan2;
        if (s1_q.nan1 | s1_q.nan2)
            s2_d.cls = CLASS_NAN;
        else if ((s1_q.inf1 & s1_q.zero2) | (s1_q.zero1 & s1_q.inf2))
            s2_d.cls = CLASS_NAN;
        else if (s1_q.inf1 | s1_q.inf2)
            s2_d.cls = CLASS_INF;
        else if (s1_q.fin1 & s1_q.fin2)
            s2_d.cls = CLASS_NORMAL;
        else
            s2_d.cls = CLASS_ZERO;
    end

    // Pipeline registers; data only moves on an actual transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (en1 & in_valid) s1_q <= s1_d;
            if (en2 & v1_q)     s2_q <= s2_d;
        end
    end

    assign out_valid   = v2_q;
    assign out_sign    = s2_q.sign;
    assign out_exp     = s2_q.exp;
    assign out_mant1   = s2_q.m1;
    assign out_mant2   = s2_q.m2;
    assign out_class   = s2_q.cls;
    assign out_invalid = s2_q.inv;

endmodule

// File: tb/tb_fp_mul_prep.sv
// Randomised scoreboard bench for fp_mul_prep (binary32 instance)
// plus a directed binary64 instance.
module tb_fp_mul_prep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [31:0]       op1, op2;
    logic              out_sign, out_invalid;
    logic signed [9:0] out_exp;
    logic [23:0]       out_mant1, out_mant2;
    logic [1:0]        out_class;

    logic               d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [63:0]        d_op1, d_op2;
    logic               d_out_sign, d_out_invalid;
    logic signed [12:0] d_out_exp;
    logic [52:0]        d_out_mant1, d_out_mant2;
    logic [1:0]         d_out_class;

    fp_mul_prep #(.IS_DOUBLE(1'b0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp),
        .out_mant1(out_mant1), .out_mant2(out_mant2),
        .out_class(out_class), .out_invalid(out_invalid)
    );

    fp_mul_prep #(.IS_DOUBLE(1'b1)) dut_d (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .op1(d_op1), .op2(d_op2),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_sign(d_out_sign), .out_exp(d_out_exp),
        .out_mant1(d_out_mant1), .out_mant2(d_out_mant2),
        .out_class(d_out_class), .out_invalid(d_out_invalid)
    );

    typedef struct {
        bit              sign;
        longint          e;
        longint unsigned m1;
        longint unsigned m2;
        int              cls;
        bit              inv;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: IEEE-754 multiply preparation from the format rules
    function automatic res_t model(longint unsigned a, longint unsigned b,
                                   int ew, int mw);
        res_t r;
        longint unsigned emax = (64'd1 << ew) - 1;
        longint unsigned fm   = (64'd1 << mw) - 1;
        longint unsigned ea   = (a >> mw) & emax;
        longint unsigned eb   = (b >> mw) & emax;
        longint unsigned fa   = a & fm;
        longint unsigned fb   = b & fm;
        bit nan_a  = (ea == emax) && (fa != 0);
        bit nan_b  = (eb == emax) && (fb != 0);
        bit inf_a  = (ea == emax) && (fa == 0);
        bit inf_b  = (eb == emax) && (fb == 0);
        bit zero_a = (ea == 0) && (fa == 0);
        bit zero_b = (eb == 0) && (fb == 0);
        bit sn_a   = nan_a && (((fa >> (mw - 1)) & 1) == 0);
        bit sn_b   = nan_b && (((fb >> (mw - 1)) & 1) == 0);
        longint bias = (longint'(1) << (ew - 1)) - 1;
        r.sign = bit'(((a >> (ew + mw)) ^ (b >> (ew + mw))) & 1);
        r.e    = longint'(ea == 0 ? 1 : ea) + longint'(eb == 0 ? 1 : eb) - bias;
        r.m1   = ((ea != 0) ? (64'd1 << mw) : 64'd0) | fa;
        r.m2   = ((eb != 0) ? (64'd1 << mw) : 64'd0) | fb;
        r.inv  = sn_a || sn_b;
        if (nan_a || nan_b) r.cls = 3;
        else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            r.cls = 3;
            r.inv = 1;
        end
        else if (inf_a || inf_b) r.cls = 2;
        else if (zero_a || zero_b) r.cls = 1;
        else r.cls = 0;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic        s = 1'($urandom_range(0, 1));
        logic [22:0] f = 23'($urandom);
        logic [7:0]  e = 8'($urandom_range(1, 254));
        case ($urandom_range(0, 7))
            0: return {s, 8'h00, 23'h0};
            1: return {s, 8'hFF, 23'h0};
            2: return {s, 8'hFF, 1'b1, f[21:0]};
            3: return {s, 8'hFF, 1'b0, f[21:1], 1'b1};
            4: return {s, 8'h00, f | 23'h1};
            default: return {s, e, f};
        endcase
    endfunction

    // One cycle: judge transfers at the negedge, then advance
    task automatic step(output bit acc);
        int   occ;
        res_t x;
        @(negedge clk);
        occ = q.size();
        acc = 0;
        check("in_ready", 64'(in_ready), 64'((occ < 2) || out_ready));
        if (out_valid) begin
            if (occ == 0) check("spurious_out", 64'(out_valid), 64'd0);
            else begin
                x = q[0];
                check("sign", 64'(out_sign), 64'(x.sign));
                check("exp", 64'(out_exp), x.e);
                check("mant1", 64'(out_mant1), x.m1);
                check("mant2", 64'(out_mant2), x.m2);
                check("class", 64'(out_class), 64'(x.cls));
                check("invalid", 64'(out_invalid), 64'(x.inv));
                if (out_ready) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(model(64'(op1), 64'(op2), 8, 23));
            acc = 1;
        end
        @(posedge clk);
        #1;
    endtask

    // Single isolated pair; returns at the negedge where out_valid shows
    task automatic send1(input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        out_ready = 1;
        in_valid  = 1;
        op1 = a;
        op2 = b;
        @(negedge clk);
        check("send_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        bit          acc;
        int          idx;
        int          n0;
        logic [31:0] pa[5];
        logic [31:0] pb[5];

        rst = 1; in_valid = 0; out_ready = 1; op1 = 0; op2 = 0;
        d_in_valid = 0; d_out_ready = 1; d_op1 = 0; d_op2 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_exp", 64'(out_exp), 64'd0);
        check("rst_mant1", 64'(out_mant1), 64'd0);
        check("rst_class", 64'(out_class), 64'd0);
        check("rst_d_valid", 64'(d_out_valid), 64'd0);
        @(posedge clk);
        #1;

        send1(32'h3FC00000, 32'h40000000, lat);
        check("n_sign", 64'(out_sign), 64'd0);
        check("n_exp", 64'(out_exp), 64'd128);
        check("n_mant1", 64'(out_mant1), 64'hC00000);
        check("n_mant2", 64'(out_mant2), 64'h800000);
        check("n_class", 64'(out_class), 64'd0);
        check("n_inv", 64'(out_invalid), 64'd0);
        @(posedge clk); #1;

        send1(32'h7F800000, 32'h00000000, lat);
        check("iz_class", 64'(out_class), 64'd3);
        check("iz_inv", 64'(out_invalid), 64'd1);
        @(posedge clk); #1;

        send1(32'hFF800000, 32'h3F800000, lat);
        check("inf_class", 64'(out_class), 64'd2);
        check("inf_sign", 64'(out_sign), 64'd1);
        check("inf_inv", 64'(out_invalid), 64'd0);
        @(posedge clk); #1;

        send1(32'h00000001, 32'h3F800000, lat);
        check("den_exp", 64'(out_exp), 64'd1);
        check("den_mant1", 64'(out_mant1), 64'h000001);
        check("den_class", 64'(out_class), 64'd0);
        @(posedge clk); #1;

        send1(32'h00800000, 32'h00800000, lat);
        check("min_exp", 64'(out_exp), -125);
        @(posedge clk); #1;

        send1(32'h7F800001, 32'h3F800000, lat);
        check("snan_class", 64'(out_class), 64'd3);
        check("snan_inv", 64'(out_invalid), 64'd1);
        @(posedge clk); #1;

        send1(32'h7FC00000, 32'h00000000, lat);
        check("qnan_class", 64'(out_class), 64'd3);
        check("qnan_inv", 64'(out_invalid), 64'd0);
        @(posedge clk); #1;

        d_in_valid = 1;
        d_op1 = 64'h3FF0000000000000;
        d_op2 = 64'hC000000000000000;
        @(posedge clk); #1;
        d_in_valid = 0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (d_out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        check("dbl_latency", 64'(lat), 64'd2);
        check("dbl_exp", 64'(d_out_exp), 64'd1024);
        check("dbl_sign", 64'(d_out_sign), 64'd1);
        check("dbl_mant1", 64'(d_out_mant1), 64'h10000000000000);
        check("dbl_class", 64'(d_out_class), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            pa[i] = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            pb[i] = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
        end
        n0 = n_out;
        idx = 0;
        out_ready = 0;
        repeat (4) begin
            in_valid = 1;
            op1 = pa[idx];
            op2 = pb[idx];
            step(acc);
            if (acc) idx++;
        end
        check("bp_accepted", 64'(idx), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1;
        for (int c = 0; c < 50 && (idx < 5 || q.size() > 0); c++) begin
            in_valid = (idx < 5);
            if (idx < 5) begin
                op1 = pa[idx];
                op2 = pb[idx];
            end
            step(acc);
            if (acc) idx++;
        end
        in_valid = 0;
        check("bp_drained", 64'(q.size()), 64'd0);
        check("bp_count", 64'(n_out - n0), 64'd5);

        out_ready = 0;
        idx = 0;
        for (int c = 0; c < 10 && idx < 2; c++) begin
            in_valid = 1;
            op1 = rand_op();
            op2 = rand_op();
            step(acc);
            if (acc) idx++;
        end
        in_valid = 0;
        check("mid_fill", 64'(idx), 64'd2);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        q.delete();
        @(negedge clk);
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_in_ready", 64'(in_ready), 64'd1);
        check("mid_exp", 64'(out_exp), 64'd0);
        check("mid_mant1", 64'(out_mant1), 64'd0);
        check("mid_class", 64'(out_class), 64'd0);
        check("mid_inv", 64'(out_invalid), 64'd0);
        @(posedge clk); #1;
        out_ready = 1;
        repeat (5) step(acc);

        repeat (400) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            op1 = rand_op();
            op2 = rand_op();
            step(acc);
        end
        in_valid = 0;
        out_ready = 1;
        for (int c = 0; c < 20 && q.size() > 0; c++) step(acc);
        check("final_drain", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
